// File: rtl/tensor_core_system_pkg.sv
// Shared constants, FSM state encoding and lane-packing helper for the tensor core system.
package tensor_core_system_pkg;

  localparam int unsigned LANE_W    = 32;
  localparam int unsigned OP_W      = 8;
  localparam int unsigned K         = 4;
  localparam int unsigned TILE      = 2;
  localparam int unsigned NUM_UNITS = 8;
  localparam int unsigned K_W       = $clog2(K);
  localparam int unsigned TILE_W    = LANE_W * TILE * TILE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Lane order: [31:0]=D00, [63:32]=D01, [95:64]=D10, [127:96]=D11.
  function automatic logic [TILE_W-1:0] pack_tile(input logic [LANE_W-1:0] d00,
                                                  input logic [LANE_W-1:0] d01,
                                                  input logic [LANE_W-1:0] d10,
                                                  input logic [LANE_W-1:0] d11);
    return {d11, d10, d01, d00};
  endfunction

endpackage

// File: rtl/tensor_core_system_threadgroup_mac.sv
// One threadgroup unit: index-derived operand generator, 2x2 accumulators, 128-bit result register.
// Ports: clock, reset (sync, active-high); load (init accumulators, mode selects C or 0);
//        step (one MAC over the current k); k (reduction index); capture (latch final tile);
//        d (packed 2x2 result, holds until next capture).
module tensor_core_system_threadgroup_mac
  import tensor_core_system_pkg::*;
#(
  parameter int unsigned UNIT_ID = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [K_W-1:0]    k,
  input  logic              mode,
  input  logic              capture,
  output logic [TILE_W-1:0] d
);

  logic [OP_W-1:0]     a_op     [TILE];
  logic [OP_W-1:0]     b_op     [TILE];
  logic [2*OP_W-1:0]   prod     [TILE][TILE];
  logic [LANE_W-1:0]   acc      [TILE][TILE];
  logic [LANE_W-1:0]   acc_next [TILE][TILE];

  // Operands A[r][k] = u+r+k, B[k][c] = k+c+1, and the next accumulator values.
  always_comb begin
    for (int i = 0; i < int'(TILE); i++) begin
      a_op[i] = OP_W'(UNIT_ID) + OP_W'(i) + OP_W'(k);
      b_op[i] = OP_W'(k) + OP_W'(i) + OP_W'(1);
    end
    for (int r = 0; r < int'(TILE); r++) begin
      for (int c = 0; c < int'(TILE); c++) begin
        prod[r][c]     = (2*OP_W)'(a_op[r]) * (2*OP_W)'(b_op[c]);
        acc_next[r][c] = acc[r][c] + LANE_W'(prod[r][c]);
      end
    end
  end

  // Capture uses acc_next so the k=3 product lands in the result on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < int'(TILE); r++) begin
        for (int c = 0; c < int'(TILE); c++) begin
          acc[r][c] <= '0;
        end
      end
      d <= '0;
    end else begin
      for (int r = 0; r < int'(TILE); r++) begin
        for (int c = 0; c < int'(TILE); c++) begin
          if (load) begin
            acc[r][c] <= mode ? LANE_W'(UNIT_ID) : '0;
          end else if (step) begin
            acc[r][c] <= acc_next[r][c];
          end
        end
      end
      if (capture) begin
        d <= pack_tile(acc_next[0][0], acc_next[0][1], acc_next[1][0], acc_next[1][1]);
      end
    end
  end

endmodule

// File: rtl/tensor_core_system.sv
// Tensor core system top: one FSM and k counter sequencing eight threadgroup MAC units,
// results presented together on a valid/ready port.
// Ports: clock, reset (sync, active-high); io_mixPc (accumulate C, sampled at start);
//        io_exec_en (execute request); io_out_ready/io_out_valid (result handshake);
//        io_out_bits_tc{t}_octet{o}_threadgroup{g}_matrix_d_data (unit u = 4t+2o+g/4).
module tensor_core_system
  import tensor_core_system_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         io_mixPc,
  input  logic         io_exec_en,
  input  logic         io_out_ready,
  output logic         io_out_valid,
  output logic [127:0] io_out_bits_tc0_octet0_threadgroup0_matrix_d_data,
  output logic [127:0] io_out_bits_tc0_octet0_threadgroup4_matrix_d_data,
  output logic [127:0] io_out_bits_tc0_octet1_threadgroup0_matrix_d_data,
  output logic [127:0] io_out_bits_tc0_octet1_threadgroup4_matrix_d_data,
  output logic [127:0] io_out_bits_tc1_octet0_threadgroup0_matrix_d_data,
  output logic [127:0] io_out_bits_tc1_octet0_threadgroup4_matrix_d_data,
  output logic [127:0] io_out_bits_tc1_octet1_threadgroup0_matrix_d_data,
  output logic [127:0] io_out_bits_tc1_octet1_threadgroup4_matrix_d_data
);

  state_t            state;
  state_t            state_next;
  logic [K_W-1:0]    k;
  logic              load_c;
  logic              step_c;
  logic              capture_c;
  logic [TILE_W-1:0] tile [NUM_UNITS];

  // State register, k counter and registered valid (follows next state, independent of ready).
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      k            <= '0;
      io_out_valid <= 1'b0;
    end else begin
      state        <= state_next;
      io_out_valid <= (state_next == DONE);
      if (load_c) begin
        k <= '0;
      end else if (step_c) begin
        k <= k + K_W'(1);
      end
    end
  end

  // Next state and unit control strobes.
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    step_c     = 1'b0;
    capture_c  = 1'b0;
    case (state)
      IDLE: begin
        if (io_exec_en) begin
          load_c     = 1'b1;
          state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        step_c = 1'b1;
        if (k == K_W'(K - 1)) begin
          capture_c  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (io_out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar u = 0; u < int'(NUM_UNITS); u++) begin : g_unit
    tensor_core_system_threadgroup_mac #(
      .UNIT_ID(u)
    ) u_mac (
      .clock  (clock),
      .reset  (reset),
      .load   (load_c),
      .step   (step_c),
      .k      (k),
      .mode   (io_mixPc),
      .capture(capture_c),
      .d      (tile[u])
    );
  end

  assign io_out_bits_tc0_octet0_threadgroup0_matrix_d_data = tile[0];
  assign io_out_bits_tc0_octet0_threadgroup4_matrix_d_data = tile[1];
  assign io_out_bits_tc0_octet1_threadgroup0_matrix_d_data = tile[2];
  assign io_out_bits_tc0_octet1_threadgroup4_matrix_d_data = tile[3];
  assign io_out_bits_tc1_octet0_threadgroup0_matrix_d_data = tile[4];
  assign io_out_bits_tc1_octet0_threadgroup4_matrix_d_data = tile[5];
  assign io_out_bits_tc1_octet1_threadgroup0_matrix_d_data = tile[6];
  assign io_out_bits_tc1_octet1_threadgroup4_matrix_d_data = tile[7];

endmodule

// File: tb/tb_tensor_core_system.sv
// Randomized self-checking bench for tensor_core_system against a matrix-arithmetic model.
module tb_tensor_core_system;

  logic         clock;
  logic         reset;
  logic         io_mixPc;
  logic         io_exec_en;
  logic         io_out_ready;
  logic         io_out_valid;
  logic [127:0] d [8];

  int n_vec;
  int n_err;

  tensor_core_system dut (
    .clock       (clock),
    .reset       (reset),
    .io_mixPc    (io_mixPc),
    .io_exec_en  (io_exec_en),
    .io_out_ready(io_out_ready),
    .io_out_valid(io_out_valid),
    .io_out_bits_tc0_octet0_threadgroup0_matrix_d_data(d[0]),
    .io_out_bits_tc0_octet0_threadgroup4_matrix_d_data(d[1]),
    .io_out_bits_tc0_octet1_threadgroup0_matrix_d_data(d[2]),
    .io_out_bits_tc0_octet1_threadgroup4_matrix_d_data(d[3]),
    .io_out_bits_tc1_octet0_threadgroup0_matrix_d_data(d[4]),
    .io_out_bits_tc1_octet0_threadgroup4_matrix_d_data(d[5]),
    .io_out_bits_tc1_octet1_threadgroup0_matrix_d_data(d[6]),
    .io_out_bits_tc1_octet1_threadgroup4_matrix_d_data(d[7])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: D = A*B (+C) with A[r][k]=u+r+k, B[k][c]=k+c+1, C=u, packed D00 in the low lane.
  function automatic logic [127:0] model_tile(input int u, input bit m);
    logic [127:0] t;
    longint       s;
    t = '0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        s = m ? longint'(u) : 0;
        for (int kk = 0; kk < 4; kk++) s += longint'((u + r + kk) * (kk + c + 1));
        t[(r*2+c)*32 +: 32] = 32'(s);
      end
    end
    return t;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input bit m);
    for (int u = 0; u < 8; u++) check($sformatf("%s_u%0d", tag, u), d[u], model_tile(u, m));
  endtask

  task automatic check_zero(input string tag);
    for (int u = 0; u < 8; u++) check($sformatf("%s_u%0d", tag, u), d[u], 128'd0);
  endtask

  // Wait for valid, counting edges from the start edge; expect five (E0..E4).
  task automatic wait_valid(input string tag, input bit m, input bit flip);
    int cyc;
    cyc = 0;
    while (cyc < 12) begin
      tick();
      cyc++;
      if (cyc == 1) io_exec_en = 1'b0;
      if (cyc == 2 && flip) io_mixPc = ~m;
      if (io_out_valid) break;
    end
    check({tag, "_latency"}, 128'(cyc), 128'd5);
    check_all(tag, m);
  endtask

  // One operation: exec pulse with mode m, then dly cycles of backpressure.
  task automatic run_op(input string tag, input bit m, input int dly, input bit flip);
    io_mixPc     = m;
    io_exec_en   = 1'b1;
    io_out_ready = (dly == 0);
    wait_valid(tag, m, flip);
    for (int i = 0; i < dly; i++) begin
      tick();
      check({tag, "_hold_valid"}, 128'(io_out_valid), 128'd1);
      check({tag, "_hold_u7"}, d[7], model_tile(7, m));
      if (i == dly - 1) io_out_ready = 1'b1;
    end
    tick();
    check({tag, "_valid_drop"}, 128'(io_out_valid), 128'd0);
    check({tag, "_data_keep"}, d[0], model_tile(0, m));
  endtask

  initial begin
    int last_v;
    int nres;
    bit m;
    n_vec        = 0;
    n_err        = 0;
    reset        = 1'b1;
    io_mixPc     = 1'b0;
    io_exec_en   = 1'b0;
    io_out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_valid", 128'(io_out_valid), 128'd0);
    check_zero("reset_data");
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_valid", 128'(io_out_valid), 128'd0);
    end
    check_zero("idle_data");

    // Directed modes, one-cycle valid and backpressure.
    run_op("mix1", 1'b1, 0, 1'b0);
    check("mix1_u0_lit", d[0], {32'd40, 32'd30, 32'd26, 32'd20});
    run_op("mix0", 1'b0, 0, 1'b0);
    check("mix0_u7_lit", d[7], {32'd138, 32'd100, 32'd124, 32'd90});
    run_op("bp", 1'b1, 5, 1'b0);
    check("bp_u7_lit", d[7], {32'd145, 32'd107, 32'd131, 32'd97});

    // Randomized modes, backpressure and mid-compute mode flips.
    for (int n = 0; n < 16; n++) begin
      run_op("rnd", 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) tick();
    end

    // Continuous exec_en and ready: five results, six cycles apart.
    m            = 1'($urandom_range(0, 1));
    io_mixPc     = m;
    io_exec_en   = 1'b1;
    io_out_ready = 1'b1;
    nres         = 0;
    last_v       = -1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick();
      if (io_out_valid) begin
        nres++;
        check_all("cont", m);
        if (last_v >= 0) check("cont_spacing", 128'(cyc - last_v), 128'd6);
        else check("cont_first", 128'(cyc), 128'd5);
        last_v = cyc;
      end
    end
    check("cont_count", 128'(nres), 128'd5);
    io_exec_en = 1'b0;
    tick();
    check("cont_idle", 128'(io_out_valid), 128'd0);

    // Reset at E2 aborts the operation; a normal one follows after release.
    io_mixPc   = 1'b1;
    io_exec_en = 1'b1;
    tick();
    io_exec_en = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("abort_valid", 128'(io_out_valid), 128'd0);
    check_zero("abort_data");
    io_exec_en = 1'b1;
    tick();
    check("abort_valid2", 128'(io_out_valid), 128'd0);
    reset        = 1'b0;
    io_mixPc     = 1'b0;
    io_out_ready = 1'b1;
    wait_valid("post_rst", 1'b0, 1'b1);
    tick();
    check("post_rst_drop", 128'(io_out_valid), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
